// File: rtl/fifo_pkg.sv
// Shared defaults, read-side state type and helpers for the dual-port RAM FIFO controller.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF    = 8;
    localparam int unsigned ADDRESS_WIDTH_DEF = 8;
    localparam int unsigned DEPTH             = 2 ** ADDRESS_WIDTH_DEF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } rd_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((2 ** res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around RAM address pointer; advances by one on inc, wrapping modulo 2**WIDTH.
module fifo_ptr #(
    parameter int unsigned WIDTH = fifo_pkg::ADDRESS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller driving a dual-port synchronous RAM:
// port 0 writes, port 1 reads with one cycle of read latency.
module dpram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned ADDRESS_WIDTH   = ADDRESS_WIDTH_DEF,
    parameter int unsigned ALMOST_FULL_LVL = 240
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     ram_cs_0,
    output logic                     ram_we_0,
    output logic                     ram_oe_0,
    output logic [ADDRESS_WIDTH-1:0] ram_address_0,
    output logic [DATA_WIDTH-1:0]    ram_din_0,
    output logic                     ram_cs_1,
    output logic                     ram_we_1,
    output logic                     ram_oe_1,
    output logic [ADDRESS_WIDTH-1:0] ram_address_1,
    output logic [DATA_WIDTH-1:0]    ram_din_1,
    input  logic [DATA_WIDTH-1:0]    ram_dout_1
);

    localparam logic [ADDRESS_WIDTH:0] AF_LVL = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_LVL);

    logic [ADDRESS_WIDTH:0] count_q, count_d;
    rd_state_e              state_q, state_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   push_acc, pop_acc;
    logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;

    // count never exceeds DEPTH, so its MSB alone marks the full state.
    assign full        = count_q[ADDRESS_WIDTH];
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_LVL);

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    always_comb begin
        count_d     = count_q;
        state_d     = pop_acc ? ST_RD_WAIT : ST_IDLE;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + (ADDRESS_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDRESS_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            state_q     <= ST_IDLE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ptr #(.WIDTH(ADDRESS_WIDTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.WIDTH(ADDRESS_WIDTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    assign ram_cs_0      = push_acc;
    assign ram_we_0      = push_acc;
    assign ram_oe_0      = 1'b0;
    assign ram_address_0 = wr_ptr;
    assign ram_din_0     = push_data;

    assign ram_cs_1      = pop_acc;
    assign ram_we_1      = 1'b0;
    assign ram_oe_1      = pop_acc;
    assign ram_address_1 = rd_ptr;
    assign ram_din_1     = '0;

    assign pop_valid = (state_q == ST_RD_WAIT);
    assign pop_data  = ram_dout_1;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: directed scenarios plus random traffic checked against a queue model.
module tb_dpram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam int AF    = 240;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] pop_data;
    logic          pop_valid, full, empty, almost_full, overflow, underflow;
    logic [AW:0]   count;
    logic          ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1;
    logic [AW-1:0] ram_address_0, ram_address_1;
    logic [DW-1:0] ram_din_0, ram_din_1;
    logic [DW-1:0] ram_dout_1 = '0;
    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int q[$];
    int wp, rp, ed;
    bit ev, ovf, unf;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(
        .DATA_WIDTH      (DW),
        .ADDRESS_WIDTH   (AW),
        .ALMOST_FULL_LVL (AF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_data     (push_data),
        .pop           (pop),
        .pop_data      (pop_data),
        .pop_valid     (pop_valid),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow),
        .ram_cs_0      (ram_cs_0),
        .ram_we_0      (ram_we_0),
        .ram_oe_0      (ram_oe_0),
        .ram_address_0 (ram_address_0),
        .ram_din_0     (ram_din_0),
        .ram_cs_1      (ram_cs_1),
        .ram_we_1      (ram_we_1),
        .ram_oe_1      (ram_oe_1),
        .ram_address_1 (ram_address_1),
        .ram_din_1     (ram_din_1),
        .ram_dout_1    (ram_dout_1)
    );

    // Stand-in for the dualportram: synchronous write on port 0, registered read on port 1.
    always @(posedge clk) begin
        if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_din_0;
        if (ram_cs_1 && ram_oe_1) ram_dout_1 <= mem[ram_address_1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit ps, input int d, input bit pp);
        int  sz;
        bit  pa, pa_ok, pp_ok;
        @(negedge clk);
        rst = r; push = ps; pop = pp; push_data = DW'(d);
        #1;
        sz    = q.size();
        pa_ok = ps && (sz < DEPTH);
        pp_ok = pp && (sz > 0);
        check_eq("count",         32'(count),       32'(sz));
        check_eq("empty",         32'(empty),       32'(sz == 0));
        check_eq("full",          32'(full),        32'(sz == DEPTH));
        check_eq("almost_full",   32'(almost_full), 32'(sz >= AF));
        check_eq("overflow",      32'(overflow),    32'(ovf));
        check_eq("underflow",     32'(underflow),   32'(unf));
        check_eq("pop_valid",     32'(pop_valid),   32'(ev));
        if (ev) check_eq("pop_data", 32'(pop_data), 32'(ed));
        check_eq("ram_cs_0",      32'(ram_cs_0),    32'(pa_ok));
        check_eq("ram_we_0",      32'(ram_we_0),    32'(pa_ok));
        check_eq("ram_oe_0",      32'(ram_oe_0),    32'(0));
        check_eq("ram_address_0", 32'(ram_address_0), 32'(wp));
        check_eq("ram_din_0",     32'(ram_din_0),   32'(d & 8'hff));
        check_eq("ram_cs_1",      32'(ram_cs_1),    32'(pp_ok));
        check_eq("ram_oe_1",      32'(ram_oe_1),    32'(pp_ok));
        check_eq("ram_we_1",      32'(ram_we_1),    32'(0));
        check_eq("ram_address_1", 32'(ram_address_1), 32'(rp));
        check_eq("ram_din_1",     32'(ram_din_1),   32'(0));
        @(posedge clk);
        if (r) begin
            q.delete();
            wp = 0; rp = 0; ev = 0; ovf = 0; unf = 0;
        end else begin
            if (ps && sz == DEPTH) ovf = 1;
            if (pp && sz == 0) unf = 1;
            ev = pp_ok;
            if (pp_ok) begin
                ed = q.pop_front();
                rp = (rp + 1) % DEPTH;
            end
            pa = pa_ok;
            if (pa) begin
                q.push_back(d & 8'hff);
                wp = (wp + 1) % DEPTH;
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        int ph_push;
        // Initial reset without checks: DUT state is unknown until the first edge.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        q.delete(); wp = 0; rp = 0; ev = 0; ovf = 0; unf = 0; ed = 0;

        // Reset then idle
        do_reset();
        step(0, 0, 0, 0);

        // Three pushes then three pops
        step(0, 1, 145, 0);
        step(0, 1, 155, 0);
        step(0, 1, 165, 0);
        repeat (3) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Fill, overflow, wrap, drain
        for (int i = 0; i < DEPTH; i++) step(0, 1, i, 0);
        step(0, 1, 99, 0);
        step(0, 0, 0, 1);
        step(0, 1, 175, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Simultaneous push+pop at count 5, then at empty
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 10 + i, 0);
        step(0, 1, 77, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 88, 1);
        step(0, 0, 0, 0);

        // Reset mid-stream with a pop pending
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 1, 30 + i, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Random traffic with phases that drift toward full or empty
        ph_push = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) ph_push = $urandom_range(15, 85);
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 99) < ph_push),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < (100 - ph_push)));
        end
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
Synchronous FIFO controller that wraps the team's dual-port synchronous RAM (dualportram) to form a single-clock FIFO.
- Port 0 of the RAM is the write port; port 1 is the read port.
- Produces the RAM strobes and addresses, and consumes the read data from port 1.
- Sits between a producer using a push interface and a consumer using a pop interface.
- RAM clk_0 and clk_1 are both tied to this block's clk at the integration level.

Parameters:
DATA_WIDTH, 8, width of the FIFO word; matches the RAM data width.
ADDRESS_WIDTH, 8, width of the RAM address; FIFO depth is 2**ADDRESS_WIDTH.
ALMOST_FULL_LVL, 240, occupancy at or above which almost_full is asserted.

Ports:
clk  input  1  single clock for the controller and both RAM ports.
rst  input  1  synchronous, active-high reset.
push  input  1  producer write request.
push_data  input  DATA_WIDTH  word to write.
pop  input  1  consumer read request.
pop_data  output  DATA_WIDTH  read word; driven directly from ram_dout_1.
pop_valid  output  1  pop_data is valid this cycle.
full  output  1  occupancy == 2**ADDRESS_WIDTH.
empty  output  1  occupancy == 0.
almost_full  output  1  occupancy >= ALMOST_FULL_LVL.
count  output  ADDRESS_WIDTH+1  current occupancy.
overflow  output  1  sticky flag: push attempted while full.
underflow  output  1  sticky flag: pop attempted while empty.
ram_cs_0, ram_we_0, ram_oe_0  output  1  port-0 strobes.
ram_address_0  output  ADDRESS_WIDTH  write address.
ram_din_0  output  DATA_WIDTH  write data.
ram_cs_1, ram_we_1, ram_oe_1  output  1  port-1 strobes.
ram_address_1  output  ADDRESS_WIDTH  read address.
ram_din_1  output  DATA_WIDTH  tied to 0.
ram_dout_1  input  DATA_WIDTH  RAM port-1 read data; valid one cycle after the read strobe.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - Reset clears wr_ptr, rd_ptr, count, pop_valid, overflow and underflow to 0.
  - After reset, empty=1 and full=almost_full=0.
  - Reset mid-operation discards the contents; pop_valid is 0 in the cycle after reset even if a read was pending.
- Accept rules:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Flags are evaluated on pre-edge state, so a simultaneous push and pop while full accepts the pop only; while empty it accepts the push only.
- Write path (combinational from push_acc):
  - ram_cs_0 = ram_we_0 = push_acc.
  - ram_oe_0 = 0.
  - ram_address_0 = wr_ptr.
  - ram_din_0 = push_data.
  - On push_acc, wr_ptr increments modulo 2**ADDRESS_WIDTH (255 wraps to 0).
- Read path:
  - ram_cs_1 = ram_oe_1 = pop_acc.
  - ram_we_1 = 0.
  - ram_address_1 = rd_ptr.
  - On pop_acc, rd_ptr increments with the same wrap.
  - pop_valid is a register that loads pop_acc, giving 1-cycle latency.
  - pop_data = ram_dout_1 and is only meaningful while pop_valid=1.
- Occupancy:
  - count increments by 1 on push_acc only, decrements by 1 on pop_acc only, and holds when both or neither occur.
  - count never exceeds 2**ADDRESS_WIDTH and never goes below 0.
  - full, empty and almost_full are combinational from count.
- Read-during-write, same address: this cannot occur, because pop is refused while empty, so rd_ptr never equals wr_ptr with a write in flight.
- Error flags:
  - overflow is set on push & full; underflow is set on pop & empty.
  - Both are sticky until rst.
  - A refused request leaves all other state unchanged.
- Control structure: two-state FSM on pop_valid (IDLE, RD_WAIT), with no back-pressure on pop_data. The consumer must take the data in the cycle pop_valid=1.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH and ADDRESS_WIDTH defaults.
  - Localparam DEPTH = 2**ADDRESS_WIDTH.
  - Function clog2.
- One sub-module, fifo_ptr: a wrap-around pointer with clk, rst and inc inputs and a ptr output. It is instantiated twice, once for writes and once for reads.
- The dualportram instance lives in the parent fifo wrapper, not inside this block.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> empty=1, full=0, count=0, pop_valid=0, all ram_cs_* = 0.
- Push 145, 155, 165, then pop 3 times -> ram_address_0 = 0, 1, 2; count rises to 3 and returns to 0; pop_data = 145, 155, 165, each on the cycle after its pop; empty=1 at the end.
- Fill test: push 256 words (value = index) -> almost_full rises when count reaches 240, full=1 at count=256; a 257th push sets overflow=1 and leaves count=256.
- Wrap: with count=256, pop 1 then push 175 -> the write goes to ram_address_0=0 (after wrap); after draining, the last pop_data = 175 and is read from address 0.
- Simultaneous push+pop at count=5 -> count stays 5 and both pointers advance; with push+pop at empty -> only the push is accepted, count becomes 1, pop_valid=0, underflow=1.
- Reset mid-stream: with count=10 and a pop issued, assert rst on the next edge -> pop_valid=0, count=0 and empty=1 in the following cycle.
